// File: rtl/lcd_bus_arb.sv
// ---------------------------------------------------------------------------
// lcd_bus_arb
//
// Arbitrates N LCD producers (init engine, line pipeline, overlays) onto one
// 8080-style parallel write bus and generates the chip-select / write-strobe
// timing. A source owns the bus for a whole burst (until it presents a word
// flagged last, or stalls longer than the hold limit); words are handed over
// with a req/ack handshake.
//
// Ports:
//   sys_clk_i   system clock, everything on the rising edge
//   reset_i     synchronous active-low reset
//   req_i       per-source word valid, held with its word until ack
//   dc_i        per-source D/C of the presented word (0 = command)
//   last_i      per-source end-of-burst flag of the presented word
//   data_i      packed source words, source k at [k*W +: W]
//   ack_o       one-cycle pulse, presented word has been captured
//   grant_o     one-hot current bus owner, zero when idle
//   cs_o        LCD chip select (active low)
//   wr_o        LCD write strobe (active low)
//   rd_o        LCD read strobe, tied inactive (write-only bus)
//   dc_o        LCD D/C
//   data_o      LCD data
//   busy_o      high whenever the sequencer is not idle
//   timeout_o   one-cycle pulse when a stalled owner is forcibly released
// ---------------------------------------------------------------------------
module lcd_bus_arb #(
  parameter int G_NUM_SRC     = 2,
  parameter int G_DATA_WIDTH  = 8,
  parameter int G_WR_LOW_CYC  = 2,
  parameter int G_WR_HIGH_CYC = 2,
  parameter int G_PRIO_MODE   = 0,
  parameter int G_HOLD_MAX    = 64
) (
  input  logic                                sys_clk_i,
  input  logic                                reset_i,
  input  logic [G_NUM_SRC-1:0]                req_i,
  input  logic [G_NUM_SRC-1:0]                dc_i,
  input  logic [G_NUM_SRC-1:0]                last_i,
  input  logic [G_NUM_SRC*G_DATA_WIDTH-1:0]   data_i,
  output logic [G_NUM_SRC-1:0]                ack_o,
  output logic [G_NUM_SRC-1:0]                grant_o,
  output logic                                cs_o,
  output logic                                wr_o,
  output logic                                rd_o,
  output logic                                dc_o,
  output logic [G_DATA_WIDTH-1:0]             data_o,
  output logic                                busy_o,
  output logic                                timeout_o
);

  localparam int PTR_W  = (G_NUM_SRC > 1) ? $clog2(G_NUM_SRC) : 1;
  localparam int PH_MAX = (G_WR_LOW_CYC > G_WR_HIGH_CYC) ? G_WR_LOW_CYC : G_WR_HIGH_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int HOLD_W = (G_HOLD_MAX > 1) ? $clog2(G_HOLD_MAX + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_LOW,
    ST_WR_HIGH,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     last_q, last_d;
  logic [G_NUM_SRC-1:0]     ack_q, ack_d;
  logic [G_NUM_SRC-1:0]     grant_q, grant_d;
  logic                     cs_q, cs_d;
  logic                     wr_q, wr_d;
  logic                     dc_q, dc_d;
  logic [G_DATA_WIDTH-1:0]  data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     timeout_q, timeout_d;

  logic [PTR_W-1:0]         win_idx;
  logic [PTR_W-1:0]         sel_idx;
  logic                     sel_req;
  logic                     sel_dc;
  logic                     sel_last;
  logic [G_DATA_WIDTH-1:0]  sel_data;
  logic [G_NUM_SRC-1:0]     sel_onehot;
  logic [HOLD_W-1:0]        hold_inc;
  logic                     capture;

  assign hold_inc = hold_q + HOLD_W'(1);

  // Winner among requesters when idle. Loops run highest-rank-last so the
  // final assignment is the winner: lowest index in fixed mode, first index
  // strictly after the pointer (wrapping) in round-robin mode.
  always_comb begin
    win_idx = '0;
    if (G_PRIO_MODE == 0) begin
      for (int i = G_NUM_SRC - 1; i >= 0; i--) begin
        if (req_i[i]) win_idx = PTR_W'(i);
      end
    end else begin
      for (int off = G_NUM_SRC; off >= 1; off--) begin
        for (int i = 0; i < G_NUM_SRC; i++) begin
          if (req_i[i] && (i == (int'(ptr_q) + off) % G_NUM_SRC)) win_idx = PTR_W'(i);
        end
      end
    end
  end

  // Source currently being looked at: the prospective winner while idle,
  // otherwise the burst owner (non-owners are ignored mid-burst).
  always_comb begin
    sel_idx    = (state_q == ST_IDLE) ? win_idx : owner_q;
    sel_req    = 1'b0;
    sel_dc     = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int i = 0; i < G_NUM_SRC; i++) begin
      if (int'(sel_idx) == i) begin
        sel_req       = req_i[i];
        sel_dc        = dc_i[i];
        sel_last      = last_i[i];
        sel_data      = data_i[i*G_DATA_WIDTH +: G_DATA_WIDTH];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Sequencer next-state and next-output logic. Outputs are computed for the
  // state being entered, so every pin is a flop aligned with the state.
  // Capturing a word always lands in SETUP with an ack to the selected source.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    last_d    = last_q;
    ack_d     = '0;
    grant_d   = grant_q;
    cs_d      = cs_q;
    wr_d      = wr_q;
    dc_d      = dc_q;
    data_d    = data_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    capture   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          capture = 1'b1;
          owner_d = win_idx;
          ptr_d   = win_idx;
          grant_d = sel_onehot;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_SETUP: begin
        state_d = ST_WR_LOW;
        wr_d    = 1'b0;
        phase_d = '0;
      end

      ST_WR_LOW: begin
        if (phase_q == PH_W'(G_WR_LOW_CYC - 1)) begin
          state_d = ST_WR_HIGH;
          wr_d    = 1'b1;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_WR_HIGH: begin
        if (phase_q == PH_W'(G_WR_HIGH_CYC - 1)) begin
          phase_d = '0;
          if (last_q) begin
            state_d = ST_GAP;
            cs_d    = 1'b1;
            grant_d = '0;
          end else if (sel_req) begin
            capture = 1'b1;
          end else begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_HOLD: begin
        // A request arriving in the timeout cycle still keeps the bus.
        if (sel_req) begin
          capture = 1'b1;
          hold_d  = '0;
        end else if ((G_HOLD_MAX != 0) && (hold_inc == HOLD_W'(G_HOLD_MAX))) begin
          state_d   = ST_GAP;
          cs_d      = 1'b1;
          grant_d   = '0;
          timeout_d = 1'b1;
          hold_d    = '0;
        end else begin
          hold_d = hold_inc;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (capture) begin
      state_d = ST_SETUP;
      data_d  = sel_data;
      dc_d    = sel_dc;
      last_d  = sel_last;
      ack_d   = sel_onehot;
    end
  end

  // State and output registers. Reset aborts any burst on the spot.
  always_ff @(posedge sys_clk_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= PTR_W'(G_NUM_SRC - 1);
      phase_q   <= '0;
      hold_q    <= '0;
      last_q    <= 1'b0;
      ack_q     <= '0;
      grant_q   <= '0;
      cs_q      <= 1'b1;
      wr_q      <= 1'b1;
      dc_q      <= 1'b1;
      data_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      dc_q      <= dc_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign ack_o     = ack_q;
  assign grant_o   = grant_q;
  assign cs_o      = cs_q;
  assign wr_o      = wr_q;
  assign rd_o      = 1'b1;
  assign dc_o      = dc_q;
  assign data_o    = data_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_lcd_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arb
//
// Directed bench for lcd_bus_arb. Three instances share one clock:
//   inst 0: fixed priority, default hold limit
//   inst 1: round-robin priority
//   inst 2: fixed priority, hold limit of 4 cycles
// A small producer per source presents queued words and advances on ack.
// Cycle numbers in the expectations count from the first SETUP cycle of a
// transaction (the cycle in which ack_o is seen), sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_lcd_bus_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3] = '{default: 1'b0};
  logic [1:0]  req   [3] = '{default: 2'b00};
  logic [1:0]  dcv   [3] = '{default: 2'b00};
  logic [1:0]  lastv [3] = '{default: 2'b00};
  logic [15:0] dat   [3] = '{default: 16'h0000};
  logic [1:0]  ack   [3];
  logic [1:0]  grant [3];
  logic        cs    [3];
  logic        wr    [3];
  logic        rd    [3];
  logic        dco   [3];
  logic [7:0]  dout  [3];
  logic        busy  [3];
  logic        tmo   [3];

  logic [9:0]  mem [3][2][8];
  int          cnt [3][2] = '{default: 0};
  int          idx [3][2] = '{default: 0};

  int errors = 0;
  int checks = 0;

  int          nEv;
  int          evCyc [8];
  logic [1:0]  evVal [8];

  lcd_bus_arb u_fix (
    .sys_clk_i(clk), .reset_i(rst_n[0]), .req_i(req[0]), .dc_i(dcv[0]),
    .last_i(lastv[0]), .data_i(dat[0]), .ack_o(ack[0]), .grant_o(grant[0]),
    .cs_o(cs[0]), .wr_o(wr[0]), .rd_o(rd[0]), .dc_o(dco[0]), .data_o(dout[0]),
    .busy_o(busy[0]), .timeout_o(tmo[0])
  );

  lcd_bus_arb #(.G_PRIO_MODE(1)) u_rr (
    .sys_clk_i(clk), .reset_i(rst_n[1]), .req_i(req[1]), .dc_i(dcv[1]),
    .last_i(lastv[1]), .data_i(dat[1]), .ack_o(ack[1]), .grant_o(grant[1]),
    .cs_o(cs[1]), .wr_o(wr[1]), .rd_o(rd[1]), .dc_o(dco[1]), .data_o(dout[1]),
    .busy_o(busy[1]), .timeout_o(tmo[1])
  );

  lcd_bus_arb #(.G_HOLD_MAX(4)) u_hold (
    .sys_clk_i(clk), .reset_i(rst_n[2]), .req_i(req[2]), .dc_i(dcv[2]),
    .last_i(lastv[2]), .data_i(dat[2]), .ack_o(ack[2]), .grant_o(grant[2]),
    .cs_o(cs[2]), .wr_o(wr[2]), .rd_o(rd[2]), .dc_o(dco[2]), .data_o(dout[2]),
    .busy_o(busy[2]), .timeout_o(tmo[2])
  );

  // Producers: on each falling edge, retire the word just acked and present
  // the next queued one, or drop req when the queue is empty.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (ack[i][k] === 1'b1) idx[i][k] = idx[i][k] + 1;
        if (idx[i][k] < cnt[i][k]) begin
          req[i][k] = 1'b1;
          {dcv[i][k], lastv[i][k], dat[i][k*8 +: 8]} = mem[i][k][idx[i][k]];
        end else begin
          req[i][k] = 1'b0;
        end
      end
    end
  end

  // Compares one observed value with its expected value and logs mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queues one word {dc, last, data} for a source of an instance.
  task automatic applyStimulus(input int inst, input int src, input logic dc,
                               input logic last, input logic [7:0] d);
    mem[inst][src][cnt[inst][src]] = {dc, last, d};
    cnt[inst][src] = cnt[inst][src] + 1;
  endtask

  // Waits (bounded) on falling edges until the instance shows the given ack.
  task automatic waitAck(input int inst, input logic [1:0] mask, input string tag);
    int n;
    n = 0;
    while (ack[inst] !== mask && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(ack[inst]), 32'(mask));
  endtask

  // Records nonzero ack cycles/values for ncyc falling edges, starting now.
  task automatic recordAcks(input int inst, input int ncyc);
    nEv = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (ack[inst] !== 2'b00 && nEv < 8) begin
        evCyc[nEv] = c;
        evVal[nEv] = ack[inst];
        nEv++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int         ackCnt, nStarts, csLow;
    int         wrStarts [3];
    logic [7:0] startData [3];
    logic       prevWr;
    int         expStart [3];
    logic [7:0] expData [3];
    int         expCyc [4];
    logic [1:0] expVal [4];

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cs",    32'(cs[0]),    32'd1);
    checkOutput("rst_wr",    32'(wr[0]),    32'd1);
    checkOutput("rst_rd",    32'(rd[0]),    32'd1);
    checkOutput("rst_dc",    32'(dco[0]),   32'd1);
    checkOutput("rst_data",  32'(dout[0]),  32'h0);
    checkOutput("rst_ack",   32'(ack[0]),   32'h0);
    checkOutput("rst_grant", 32'(grant[0]), 32'h0);
    checkOutput("rst_busy",  32'(busy[0]),  32'd0);
    checkOutput("rst_tmo",   32'(tmo[0]),   32'd0);
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    repeat (2) @(posedge clk);

    // ---------------- single word from src0 ----------------
    #2;
    applyStimulus(0, 0, 1'b0, 1'b1, 8'hA5);
    @(negedge clk);
    waitAck(0, 2'b01, "single_ack");
    checkOutput("single_c0_cs",    32'(cs[0]),    32'd0);
    checkOutput("single_c0_data",  32'(dout[0]),  32'hA5);
    checkOutput("single_c0_dc",    32'(dco[0]),   32'd0);
    checkOutput("single_c0_grant", 32'(grant[0]), 32'h1);
    checkOutput("single_c0_wr",    32'(wr[0]),    32'd1);
    @(negedge clk);
    checkOutput("single_c1_wr",    32'(wr[0]),    32'd0);
    checkOutput("single_c1_ack",   32'(ack[0]),   32'h0);
    @(negedge clk);
    checkOutput("single_c2_wr",    32'(wr[0]),    32'd0);
    @(negedge clk);
    checkOutput("single_c3_wr",    32'(wr[0]),    32'd1);
    checkOutput("single_c3_data",  32'(dout[0]),  32'hA5);
    @(negedge clk);
    checkOutput("single_c4_cs",    32'(cs[0]),    32'd0);
    @(negedge clk);
    checkOutput("single_c5_cs",    32'(cs[0]),    32'd1);
    checkOutput("single_c5_grant", 32'(grant[0]), 32'h0);
    checkOutput("single_c5_busy",  32'(busy[0]),  32'd1);
    @(negedge clk);
    checkOutput("single_c6_busy",  32'(busy[0]),  32'd0);
    repeat (3) @(negedge clk);

    // ---------------- 3-word burst from src1 ----------------
    @(posedge clk); #2;
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h11);
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h22);
    applyStimulus(0, 1, 1'b1, 1'b1, 8'h33);
    @(negedge clk);
    waitAck(0, 2'b10, "burst_ack");
    checkOutput("burst_dc", 32'(dco[0]), 32'd1);
    ackCnt = 0; nStarts = 0; csLow = 0; prevWr = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (ack[0][1]) ackCnt++;
      if (!wr[0] && prevWr) begin
        if (nStarts < 3) begin
          wrStarts[nStarts]  = c;
          startData[nStarts] = dout[0];
        end
        nStarts++;
      end
      prevWr = wr[0];
      if (c < 15 && !cs[0]) csLow++;
      if (c == 15) checkOutput("burst_gap_cs", 32'(cs[0]), 32'd1);
      if (c < 15) @(negedge clk);
    end
    checkOutput("burst_ack_count", 32'(ackCnt), 32'd3);
    checkOutput("burst_wr_pulses", 32'(nStarts), 32'd3);
    checkOutput("burst_cs_low",    32'(csLow),   32'd15);
    expStart = '{1, 6, 11};
    expData  = '{8'h11, 8'h22, 8'h33};
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("burst_wr_start%0d", j), 32'(wrStarts[j]),  32'(expStart[j]));
      checkOutput($sformatf("burst_data%0d", j),     32'(startData[j]), 32'(expData[j]));
    end
    repeat (3) @(negedge clk);

    // ---------------- fixed priority, both request 2-word bursts ----------------
    @(posedge clk); #2;
    applyStimulus(0, 0, 1'b0, 1'b0, 8'h01);
    applyStimulus(0, 0, 1'b0, 1'b1, 8'h02);
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h03);
    applyStimulus(0, 1, 1'b1, 1'b1, 8'h04);
    @(negedge clk);
    waitAck(0, 2'b01, "fixed_first_ack");
    recordAcks(0, 20);
    checkOutput("fixed_ack_events", 32'(nEv), 32'd4);
    expCyc = '{0, 5, 12, 17};
    expVal = '{2'b01, 2'b01, 2'b10, 2'b10};
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("fixed_ev%0d_cyc", j), 32'(evCyc[j]), 32'(expCyc[j]));
      checkOutput($sformatf("fixed_ev%0d_src", j), 32'(evVal[j]), 32'(expVal[j]));
    end
    repeat (8) @(negedge clk);
    checkOutput("fixed_idle_after", 32'(busy[0]), 32'd0);

    // ---------------- round robin, repeated single-word bursts ----------------
    @(posedge clk); #2;
    applyStimulus(1, 0, 1'b1, 1'b1, 8'h40);
    applyStimulus(1, 0, 1'b1, 1'b1, 8'h41);
    applyStimulus(1, 1, 1'b1, 1'b1, 8'h50);
    applyStimulus(1, 1, 1'b1, 1'b1, 8'h51);
    @(negedge clk);
    waitAck(1, 2'b01, "rr_first_ack");
    recordAcks(1, 25);
    checkOutput("rr_ack_events", 32'(nEv), 32'd4);
    expCyc = '{0, 7, 14, 21};
    expVal = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("rr_ev%0d_cyc", j), 32'(evCyc[j]), 32'(expCyc[j]));
      checkOutput($sformatf("rr_ev%0d_src", j), 32'(evVal[j]), 32'(expVal[j]));
    end

    // ---------------- hold timeout with pending src1 ----------------
    @(posedge clk); #2;
    applyStimulus(2, 0, 1'b1, 1'b0, 8'h5A);
    applyStimulus(2, 1, 1'b1, 1'b1, 8'h77);
    @(negedge clk);
    waitAck(2, 2'b01, "hold_first_ack");
    for (int c = 0; c < 12; c++) begin
      case (c)
        5: begin
          checkOutput("hold_c5_cs",    32'(cs[2]),    32'd0);
          checkOutput("hold_c5_wr",    32'(wr[2]),    32'd1);
          checkOutput("hold_c5_data",  32'(dout[2]),  32'h5A);
        end
        8: begin
          checkOutput("hold_c8_cs",    32'(cs[2]),    32'd0);
          checkOutput("hold_c8_grant", 32'(grant[2]), 32'h1);
          checkOutput("hold_c8_tmo",   32'(tmo[2]),   32'd0);
        end
        9: begin
          checkOutput("hold_c9_tmo",   32'(tmo[2]),   32'd1);
          checkOutput("hold_c9_cs",    32'(cs[2]),    32'd1);
          checkOutput("hold_c9_grant", 32'(grant[2]), 32'h0);
        end
        10: begin
          checkOutput("hold_c10_tmo",  32'(tmo[2]),   32'd0);
          checkOutput("hold_c10_busy", 32'(busy[2]),  32'd0);
        end
        11: begin
          checkOutput("hold_c11_ack",   32'(ack[2]),   32'h2);
          checkOutput("hold_c11_grant", 32'(grant[2]), 32'h2);
          checkOutput("hold_c11_data",  32'(dout[2]),  32'h77);
        end
        default: ;
      endcase
      if (c < 11) @(negedge clk);
    end

    // ---------------- reset during WR_LOW ----------------
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    applyStimulus(0, 0, 1'b0, 1'b0, 8'hC1);
    applyStimulus(0, 0, 1'b0, 1'b0, 8'hC2);
    applyStimulus(0, 0, 1'b0, 1'b1, 8'hC3);
    @(negedge clk);
    waitAck(0, 2'b01, "rst_burst_ack");
    @(negedge clk);
    checkOutput("rst_burst_wrlow", 32'(wr[0]), 32'd0);
    rst_n[0] = 1'b0;
    cnt[0][0] = idx[0][0];
    @(negedge clk);
    checkOutput("midrst_cs",    32'(cs[0]),    32'd1);
    checkOutput("midrst_wr",    32'(wr[0]),    32'd1);
    checkOutput("midrst_grant", 32'(grant[0]), 32'h0);
    checkOutput("midrst_data",  32'(dout[0]),  32'h0);
    checkOutput("midrst_busy",  32'(busy[0]),  32'd0);
    checkOutput("midrst_dc",    32'(dco[0]),   32'd1);
    @(posedge clk); #2;
    rst_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_stays_idle", 32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
